// File: rtl/rv32i_instr_encoder.sv
// RV32I field-to-word encoder: legality-checks each request, packs it per instruction
// format and buffers the result in a small valid/ready FIFO with saturating counters.
module rv32i_instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] encoded_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011
    } opcode_e;

    logic [31:0] enc_raw;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic [6:0]  funct7;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;
    logic        is_shift;

    // Range checks: upper bits must all replicate the format's sign bit.
    always_comb begin
        funct7   = in_alt ? 7'h20 : 7'h00;
        imm_i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
        imm_b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
        imm_j_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
        is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    end

    always_comb begin
        enc_raw     = '0;
        enc_illegal = 1'b0;
        case (opcode_e'(in_opcode))
            OP_LUI, OP_AUIPC: begin
                enc_raw     = {in_imm[31:12], in_rd, in_opcode};
                enc_illegal = in_alt || (|in_imm[11:0]);
            end
            OP_JAL: begin
                enc_raw     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_illegal = in_alt || !imm_j_ok;
            end
            OP_JALR: begin
                enc_raw     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_illegal = in_alt || (in_funct3 != 3'b000) || !imm_i_ok;
            end
            OP_BR: begin
                enc_raw     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
                enc_illegal = in_alt || (in_funct3 == 3'b010) || (in_funct3 == 3'b011) || !imm_b_ok;
            end
            OP_LOAD: begin
                enc_raw     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_illegal = in_alt || (in_funct3 == 3'b011) || (in_funct3 == 3'b110)
                              || (in_funct3 == 3'b111) || !imm_i_ok;
            end
            OP_STORE: begin
                enc_raw     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_illegal = in_alt || (in_funct3 >= 3'b011) || !imm_i_ok;
            end
            OP_IMM: begin
                if (is_shift) begin
                    enc_raw     = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_illegal = (in_alt && (in_funct3 != 3'b101)) || (|in_imm[31:5]);
                end else begin
                    enc_raw     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_illegal = in_alt || !imm_i_ok;
                end
            end
            OP_REG: begin
                enc_raw     = {funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_illegal = in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
            end
            default: enc_illegal = 1'b1;
        endcase
        enc_word = enc_illegal ? '0 : enc_raw;
    end

    logic [31:0]      mem_instr [DEPTH];
    logic             mem_ill   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push;
    logic             pop;

    always_comb begin
        full      = (count == FULL_CNT);
        in_ready  = rst_n && !full;
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    assign out_instr   = mem_instr[rd_ptr];
    assign out_illegal = mem_ill[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_ill[i]   <= 1'b0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            encoded_count <= '0;
            illegal_count <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc_word;
                mem_ill[wr_ptr]   <= enc_illegal;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                if (enc_illegal) begin
                    if (illegal_count != '1) illegal_count <= illegal_count + CNT_W'(1);
                end else begin
                    if (encoded_count != '1) encoded_count <= encoded_count + CNT_W'(1);
                end
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (pop && !push) count <= count - (PTR_W + 1)'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized and directed bench for rv32i_instr_encoder against a format-table
// reference model and an ideal FIFO queue.
module tb_rv32i_instr_encoder;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic             in_alt = 1'b0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             out_illegal;
    logic [CNT_W-1:0] encoded_count;
    logic [CNT_W-1:0] illegal_count;

    rv32i_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal),
        .encoded_count(encoded_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] mq[$];
    int          m_enc = 0;
    int          m_ill = 0;
    logic [6:0]  legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned pack(longint unsigned op, longint unsigned rd,
                                             longint unsigned f3, longint unsigned rs1,
                                             longint unsigned rs2, longint unsigned f7);
        return op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
    endfunction

    function automatic bit fits(longint s, int n);
        return (s >= -(64'sd1 <<< (n - 1))) && (s < (64'sd1 <<< (n - 1)));
    endfunction

    // Every format is an R-type layout with some fields reinterpreted as immediate slices.
    function automatic logic [32:0] model(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                          logic [4:0] rs2, logic [2:0] f3, logic alt,
                                          logic [31:0] imm);
        longint          s = longint'($signed(imm));
        longint unsigned u = {32'h0, imm};
        longint unsigned w = 0;
        longint unsigned v;
        bit              ill = 1'b0;
        case (op)
            7'b0110111, 7'b0010111: begin
                ill = alt || (u % 4096 != 0);
                w = pack(op, rd, (u >> 12) & 7, (u >> 15) & 31, (u >> 20) & 31, (u >> 25) & 127);
            end
            7'b1101111: begin
                ill = alt || !fits(s, 21) || (u % 2 != 0);
                v = (((u >> 20) & 1) << 19) + (((u >> 1) & 1023) << 9)
                    + (((u >> 11) & 1) << 8) + ((u >> 12) & 255);
                w = op + rd * 128 + v * 4096;
            end
            7'b1100111: begin
                ill = alt || (f3 != 0) || !fits(s, 12);
                w = pack(op, rd, f3, rs1, u & 31, (u >> 5) & 127);
            end
            7'b1100011: begin
                ill = alt || (f3 == 2) || (f3 == 3) || !fits(s, 13) || (u % 2 != 0);
                w = pack(op, ((u >> 1) & 15) * 2 + ((u >> 11) & 1), f3, rs1, rs2,
                         ((u >> 12) & 1) * 64 + ((u >> 5) & 63));
            end
            7'b0000011: begin
                ill = alt || (f3 == 3) || (f3 >= 6) || !fits(s, 12);
                w = pack(op, rd, f3, rs1, u & 31, (u >> 5) & 127);
            end
            7'b0100011: begin
                ill = alt || (f3 >= 3) || !fits(s, 12);
                w = pack(op, u & 31, f3, rs1, rs2, (u >> 5) & 127);
            end
            7'b0010011: begin
                if (f3 == 1 || f3 == 5) begin
                    ill = (alt && f3 != 5) || (u >= 32);
                    w = pack(op, rd, f3, rs1, u & 31, alt ? 32 : 0);
                end else begin
                    ill = alt || !fits(s, 12);
                    w = pack(op, rd, f3, rs1, u & 31, (u >> 5) & 127);
                end
            end
            7'b0110011: begin
                ill = alt && !(f3 == 0 || f3 == 5);
                w = pack(op, rd, f3, rs1, rs2, alt ? 32 : 0);
            end
            default: ill = 1'b1;
        endcase
        if (ill) w = 0;
        return {ill, w[31:0]};
    endfunction

    task automatic set_req(input logic v, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic alt, input logic [31:0] imm);
        in_valid = v; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_alt = alt; in_imm = imm;
    endtask

    task automatic check_state();
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_instr", 64'(out_instr), 64'(mq[0][31:0]));
            check("out_illegal", 64'(out_illegal), 64'(mq[0][32]));
        end
        check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check("encoded_count", 64'(encoded_count), 64'(m_enc));
        check("illegal_count", 64'(illegal_count), 64'(m_ill));
    endtask

    task automatic cycle();
        bit          acc;
        bit          pop;
        logic [32:0] e;
        acc = in_valid && (mq.size() < DEPTH);
        pop = out_ready && (mq.size() != 0);
        e   = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(e);
            if (e[32]) begin
                if (m_ill < SAT) m_ill++;
            end else begin
                if (m_enc < SAT) m_enc++;
            end
        end
        check_state();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_instr"}, 64'(out_instr), 64'(0));
        check({tag, "_illegal"}, 64'(out_illegal), 64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_enc_cnt"}, 64'(encoded_count), 64'(0));
        check({tag, "_ill_cnt"}, 64'(illegal_count), 64'(0));
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
            2:       return 32'($urandom_range(0, 40));
            3:       return $urandom & 32'hFFFFF000;
            default: return 32'(int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20)) & 32'hFFFFFFFE;
        endcase
    endfunction

    initial begin
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_state();
        out_ready = 1'b1;

        // Directed examples
        set_req(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd5);
        cycle();
        check("addi_word", 64'(out_instr), 64'h00500093);
        check("addi_cnt", 64'(encoded_count), 64'd1);
        set_req(1, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1, 32'd0);
        cycle();
        check("sub_word", 64'(out_instr), 64'h402081B3);
        set_req(1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 0, 32'hFFFFFFFC);
        cycle();
        check("beq_word", 64'(out_instr), 64'hFE208EE3);
        set_req(1, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd8);
        cycle();
        check("jal_word", 64'(out_instr), 64'h008000EF);

        set_req(1, 7'b0000011, 5'd1, 5'd2, 5'd0, 3'd3, 0, 32'd0);
        cycle();
        check("ill_load", 64'({out_illegal, out_instr}), 64'h1_0000_0000);
        set_req(1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 0, 32'd3);
        cycle();
        check("ill_br", 64'({out_illegal, out_instr}), 64'h1_0000_0000);
        set_req(1, 7'b0110111, 5'd4, 5'd0, 5'd0, 3'd0, 0, 32'h0000_1001);
        cycle();
        check("ill_lui", 64'({out_illegal, out_instr}), 64'h1_0000_0000);
        check("ill_cnt3", 64'(illegal_count), 64'd3);
        check("enc_cnt4", 64'(encoded_count), 64'd4);
        in_valid = 1'b0;
        cycle();

        // Backpressure: third request held until the first pop
        out_ready = 1'b0;
        set_req(1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 0, 32'd1);
        cycle();
        set_req(1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 0, 32'd2);
        cycle();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        set_req(1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 0, 32'd3);
        cycle();
        check("bp_head_held", 64'(out_instr), 64'h00130293);
        out_ready = 1'b1;
        cycle();
        check("bp_second", 64'(out_instr), 64'h00230293);
        cycle();
        check("bp_third", 64'(out_instr), 64'h00330293);
        in_valid = 1'b0;
        cycle();

        // Reset with FIFO full
        out_ready = 1'b0;
        set_req(1, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd5, 1, 32'd0);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        mq.delete();
        m_enc = 0;
        m_ill = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_req(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd5);
        cycle();
        check("post_rst_addi", 64'(out_instr), 64'h00500093);
        in_valid = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            set_req($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)],
                    5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                    $urandom_range(0, 3) == 0, rand_imm());
            out_ready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
